// File: rtl/blockmem_rd_burst_if.sv
// Bundle of the command, memory read-port and output-stream signals of blockmem_rd_burst.
// The master modport is the burst engine; the slave modport is its surroundings (memory, requester, sink).
interface blockmem_rd_burst_if #(
  parameter int G_MEMWIDTH = 32,
  parameter int G_MEMDEPTH = 1024,
  parameter int G_LENWIDTH = 8
);
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH);

  // Handshakes (cmd_*, m_*): a transfer happens on a rising clk edge where valid and ready are
  // both 1; a valid source holds its payload stable until that edge, and ready may depend on state only.
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [G_ADDRWIDTH-1:0] cmd_addr;
  logic [G_LENWIDTH-1:0]  cmd_len;
  logic                   enb;
  logic [G_ADDRWIDTH-1:0] addrb;
  logic [G_MEMWIDTH-1:0]  doutb;
  logic                   m_valid;
  logic                   m_ready;
  logic [G_MEMWIDTH-1:0]  m_data;
  logic                   m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, doutb, m_ready,
    output cmd_ready, enb, addrb, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, doutb, m_ready,
    input  cmd_ready, enb, addrb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/blockmem_rd_burst.sv
// Read-burst engine for the block memory read port: sequential reads, 1-cycle latency absorbed by a 2-entry FIFO.
// Optional stall counter output enabled by defining BLOCKMEM_RD_BURST_STALL_CNT_EN.
module blockmem_rd_burst #(
  parameter int G_MEMWIDTH = 32,
  parameter int G_MEMDEPTH = 1024,
  parameter int G_LENWIDTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  blockmem_rd_burst_if.master bus,
  output logic                busy,
  output logic [1:0]          dbg_state
`ifdef BLOCKMEM_RD_BURST_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH);
  localparam int REM_W       = G_LENWIDTH + 1;
  localparam logic [G_ADDRWIDTH-1:0] LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [G_ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [G_ADDRWIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [REM_W-1:0]       remaining_q, remaining_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;
  logic [G_MEMWIDTH-1:0]  fifo_data_q [2];
  logic [G_MEMWIDTH-1:0]  fifo_data_d [2];
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic                   wr_idx_q, wr_idx_d;
  logic                   rd_idx_q, rd_idx_d;
  logic [1:0]             occ_q, occ_d;

  logic       m_valid_int;
  logic       pop;
  logic       cmd_hs;
  logic       issue;
  logic [2:0] credit_sum;

  assign m_valid_int = (occ_q != 2'd0);
  assign pop         = m_valid_int & bus.m_ready;
  assign cmd_hs      = (state_q == S_IDLE) & bus.cmd_valid;

  // Count the read in flight as occupied so a sink that stops accepting can never overflow the FIFO.
  assign credit_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == S_RUN) && (remaining_q != '0) && (credit_sum < 3'd2);

  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    addr_hold_d     = addr_hold_q;
    remaining_d     = remaining_q;
    inflight_d      = 1'b0;
    inflight_last_d = inflight_last_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    occ_d           = occ_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rd_ptr_d    = bus.cmd_addr;
          remaining_d = REM_W'(bus.cmd_len) + REM_W'(1);
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          // Depth need not be a power of two, so wrap explicitly at the last word.
          rd_ptr_d        = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + G_ADDRWIDTH'(1);
          addr_hold_d     = rd_ptr_q;
          remaining_d     = remaining_q - REM_W'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (remaining_q == REM_W'(1));
          if (remaining_q == REM_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_idx_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (inflight_q) begin
      fifo_data_d[wr_idx_q] = bus.doutb;
      fifo_last_d[wr_idx_q] = inflight_last_q;
      wr_idx_d              = ~wr_idx_q;
    end
    if (pop) begin
      rd_idx_d = ~rd_idx_q;
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      rd_ptr_q        <= '0;
      addr_hold_q     <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '0;
      wr_idx_q        <= 1'b0;
      rd_idx_q        <= 1'b0;
      occ_q           <= '0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      addr_hold_q     <= addr_hold_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      occ_q           <= occ_d;
    end
  end

  // addrb keeps the last issued address while idle rather than tracking the advancing pointer.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.enb       = issue;
  assign bus.addrb     = issue ? rd_ptr_q : addr_hold_q;
  assign bus.m_valid   = m_valid_int;
  assign bus.m_data    = fifo_data_q[rd_idx_q];
  assign bus.m_last    = m_valid_int & fifo_last_q[rd_idx_q];
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

`ifdef BLOCKMEM_RD_BURST_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cmd_hs) begin
      stall_cnt_d = '0;
    end else if (m_valid_int && !bus.m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_cmd_hs;
  assign unused_cmd_hs = cmd_hs;
`endif
endmodule
